// File: rtl/multi_btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_btn_debouncer
//  Description : N-channel front-panel button conditioner. Each channel has
//                a two-flop synchroniser, a debounce counter and a
//                press-classification FSM (IDLE / PRESSED / LONG).
//                Ports:
//                  clk           system clock
//                  rst           synchronous active-high reset
//                  btn_in        raw asynchronous button inputs
//                  btn_level     debounced level, 1 = pressed
//                  press_pulse   one-cycle pulse on accepted press
//                  release_pulse one-cycle pulse on accepted release
//                  short_pulse   release seen before long_pulse fired
//                  long_pulse    hold reached LONG_CYCLES
//                  repeat_pulse  every REPEAT_CYCLES while in LONG
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_btn_debouncer #(
    parameter int N_CH            = 4,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_W          = 26,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] short_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam logic [N_CH-1:0]   c_inv_mask = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : '0;
    localparam logic [CNT_W-1:0]  c_db_tc    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_long_tc  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_rep_tc   = HOLD_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_pressed = 2'd1;
    localparam logic [1:0] c_st_long    = 2'd2;

    // Polarity is normalised before the synchroniser so everything
    // downstream works in "1 = pressed" terms.
    logic [N_CH-1:0] r_s0;
    logic [N_CH-1:0] r_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= '0;
            r_s1 <= '0;
        end else begin
            r_s0 <= btn_in ^ c_inv_mask;
            r_s1 <= r_s0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0]  r_cnt;
        logic              r_level;
        logic [1:0]        r_state;
        logic [1:0]        w_state_nxt;
        logic [HOLD_W-1:0] r_hcnt;
        logic [HOLD_W-1:0] w_hcnt_nxt;
        logic              w_accept;
        logic              w_press_acc;
        logic              w_rel_acc;
        logic              w_press;
        logic              w_rel;
        logic              w_short;
        logic              w_long;
        logic              w_rep;
        logic              r_press;
        logic              r_rel;
        logic              r_short;
        logic              r_long;
        logic              r_rep;

        // Accept happens on the same edge that updates r_level, so the FSM
        // pulses line up with the level change.
        assign w_accept    = (r_s1[i] != r_level) && (r_cnt == c_db_tc);
        assign w_press_acc = w_accept &  r_s1[i];
        assign w_rel_acc   = w_accept & ~r_s1[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_s1[i] == r_level) begin
                r_cnt   <= '0;
            end else if (r_cnt == c_db_tc) begin
                r_level <= r_s1[i];
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end

        // Release takes priority over long / repeat terminal counts.
        always_comb begin
            w_state_nxt = r_state;
            w_hcnt_nxt  = r_hcnt;
            w_press     = 1'b0;
            w_rel       = 1'b0;
            w_short     = 1'b0;
            w_long      = 1'b0;
            w_rep       = 1'b0;
            case (r_state)
                c_st_idle: begin
                    w_hcnt_nxt = '0;
                    if (w_press_acc) begin
                        w_state_nxt = c_st_pressed;
                        w_press     = 1'b1;
                    end
                end
                c_st_pressed: begin
                    if (w_rel_acc) begin
                        w_state_nxt = c_st_idle;
                        w_rel       = 1'b1;
                        w_short     = 1'b1;
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt == c_long_tc) begin
                        w_state_nxt = c_st_long;
                        w_long      = 1'b1;
                        w_hcnt_nxt  = '0;
                    end else begin
                        w_hcnt_nxt  = r_hcnt + 1'b1;
                    end
                end
                c_st_long: begin
                    if (w_rel_acc) begin
                        w_state_nxt = c_st_idle;
                        w_rel       = 1'b1;
                        w_hcnt_nxt  = '0;
                    end else if (REPEAT_EN != 0) begin
                        if (r_hcnt == c_rep_tc) begin
                            w_rep      = 1'b1;
                            w_hcnt_nxt = '0;
                        end else begin
                            w_hcnt_nxt = r_hcnt + 1'b1;
                        end
                    end else begin
                        w_hcnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= c_st_idle;
                r_hcnt  <= '0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_short <= 1'b0;
                r_long  <= 1'b0;
                r_rep   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_hcnt  <= w_hcnt_nxt;
                r_press <= w_press;
                r_rel   <= w_rel;
                r_short <= w_short;
                r_long  <= w_long;
                r_rep   <= w_rep;
            end
        end

        assign btn_level[i]     = r_level;
        assign press_pulse[i]   = r_press;
        assign release_pulse[i] = r_rel;
        assign short_pulse[i]   = r_short;
        assign long_pulse[i]    = r_long;
        assign repeat_pulse[i]  = r_rep;
    end

endmodule
`default_nettype wire
